// File: rtl/param_reorder_buffer.sv
// In-order reorder buffer: circular entry array with head/tail pointers, multi-port
// CDB writeback, bypassed operand query port and a single in-order commit port.
module param_reorder_buffer #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int AREG_W  = 5,
  parameter int NUM_CDB = 2,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      allocate,
  input  logic [AREG_W-1:0]         dest_arch_reg,
  input  logic                      is_store,
  output logic [TAG_W-1:0]          alloc_tag,
  output logic                      rob_full,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
  input  logic [NUM_CDB-1:0]        cdb_exc,
  input  logic [TAG_W-1:0]          query_tag,
  output logic                      query_ready,
  output logic [DATA_W-1:0]         query_val,
  output logic                      commit_valid,
  output logic                      commit_is_store,
  output logic                      commit_exc,
  output logic [AREG_W-1:0]         commit_arch_reg,
  output logic [DATA_W-1:0]         commit_val,
  output logic [TAG_W-1:0]          commit_tag,
  input  logic                      commit_ack,
  output logic [CNT_W-1:0]          count,
  output logic                      rob_empty
);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_q, ready_q, exc_q, store_q;
  logic [AREG_W-1:0] areg_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [TAG_W-1:0]  tag_w [NUM_CDB];
  logic [DATA_W-1:0] val_w [NUM_CDB];

  genvar g;
  generate
    for (g = 0; g < NUM_CDB; g++) begin : g_cdb
      assign tag_w[g] = cdb_tag[g*TAG_W +: TAG_W];
      assign val_w[g] = cdb_val[g*DATA_W +: DATA_W];
    end
  endgenerate

  logic alloc_ok, commit_fire;

  assign rob_full        = (count_q == FULL_CNT);
  assign rob_empty       = (count_q == '0);
  assign count           = count_q;
  assign alloc_tag       = tail_q;
  assign alloc_ok        = allocate && !rob_full;
  assign commit_valid    = valid_q[head_q] && ready_q[head_q];
  assign commit_fire     = commit_valid && commit_ack;
  assign commit_tag      = head_q;
  assign commit_is_store = store_q[head_q];
  assign commit_exc      = exc_q[head_q];
  assign commit_arch_reg = areg_q[head_q];
  assign commit_val      = value_q[head_q];

  // Control state; ascending port loop makes the highest-index CDB port win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ready_q <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      ready_q <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CDB; i++) begin
        if (cdb_valid[i] && valid_q[tag_w[i]]) begin
          ready_q[tag_w[i]] <= 1'b1;
          exc_q[tag_w[i]]   <= cdb_exc[i];
        end
      end
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      // Tail entry is never valid when allocation is accepted, so no CDB overlap.
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        exc_q[tail_q]   <= 1'b0;
        tail_q          <= tail_q + TAG_W'(1);
      end
      case ({alloc_ok, commit_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed once ready/valid say so.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid[i] && valid_q[tag_w[i]]) value_q[tag_w[i]] <= val_w[i];
    end
    if (alloc_ok) begin
      areg_q[tail_q]  <= dest_arch_reg;
      store_q[tail_q] <= is_store;
    end
  end

  always_comb begin
    query_ready = ready_q[query_tag];
    query_val   = value_q[query_tag];
    for (int i = 0; i < NUM_CDB; i++) begin
      if (cdb_valid[i] && tag_w[i] == query_tag) begin
        query_ready = 1'b1;
        query_val   = val_w[i];
      end
    end
  end
endmodule

// File: tb/tb_param_reorder_buffer.sv
// Directed + randomized bench for param_reorder_buffer against a queue-based ROB model.
module tb_param_reorder_buffer;
  localparam int DEPTH = 8, DATA_W = 32, AREG_W = 5, NUM_CDB = 2;
  localparam int TAG_W = 3, CNT_W = 4;

  logic                      clk = 1'b0;
  logic                      reset, flush, allocate, is_store, commit_ack;
  logic [AREG_W-1:0]         dest_arch_reg;
  logic [TAG_W-1:0]          alloc_tag, query_tag, commit_tag;
  logic                      rob_full, rob_empty, query_ready;
  logic [NUM_CDB-1:0]        cdb_valid, cdb_exc;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_val;
  logic [DATA_W-1:0]         query_val, commit_val;
  logic                      commit_valid, commit_is_store, commit_exc;
  logic [AREG_W-1:0]         commit_arch_reg;
  logic [CNT_W-1:0]          count;

  param_reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AREG_W(AREG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .reset(reset), .flush(flush), .allocate(allocate),
    .dest_arch_reg(dest_arch_reg), .is_store(is_store), .alloc_tag(alloc_tag),
    .rob_full(rob_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_exc(cdb_exc), .query_tag(query_tag), .query_ready(query_ready),
    .query_val(query_val), .commit_valid(commit_valid), .commit_is_store(commit_is_store),
    .commit_exc(commit_exc), .commit_arch_reg(commit_arch_reg), .commit_val(commit_val),
    .commit_tag(commit_tag), .commit_ack(commit_ack), .count(count), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  // Model: program-order queue of live tags plus per-tag status.
  bit              m_valid [DEPTH];
  bit              m_ready [DEPTH];
  bit              m_exc   [DEPTH];
  bit              m_store [DEPTH];
  logic [31:0]     m_val   [DEPTH];
  logic [4:0]      m_areg  [DEPTH];
  int              q[$];
  int              m_tail;
  int              checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_ready[i] = 0; m_exc[i] = 0;
    end
  endtask

  function automatic int m_head();
    return (q.size() > 0) ? q[0] : m_tail;
  endfunction

  task automatic check_outs();
    int h; bit cv; bit qr; logic [31:0] qv;
    h  = m_head();
    cv = (q.size() > 0) && m_ready[h];
    chk("count", count, q.size());
    chk("rob_full", rob_full, q.size() == DEPTH);
    chk("rob_empty", rob_empty, q.size() == 0);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("commit_valid", commit_valid, cv);
    chk("commit_tag", commit_tag, h);
    if (cv) begin
      chk("commit_val", commit_val, m_val[h]);
      chk("commit_exc", commit_exc, m_exc[h]);
      chk("commit_arch_reg", commit_arch_reg, m_areg[h]);
      chk("commit_is_store", commit_is_store, m_store[h]);
    end
    qr = m_ready[query_tag];
    qv = m_val[query_tag];
    for (int i = 0; i < NUM_CDB; i++)
      if (cdb_valid[i] && cdb_tag[i*TAG_W +: TAG_W] == query_tag) begin
        qr = 1; qv = cdb_val[i*DATA_W +: DATA_W];
      end
    chk("query_ready", query_ready, qr);
    if (qr) chk("query_val", query_val, qv);
  endtask

  task automatic model_edge();
    int h; bit fire; bit acc; int t;
    if (flush) begin m_clear(); return; end
    h    = m_head();
    fire = (q.size() > 0) && m_ready[h] && commit_ack;
    acc  = allocate && (q.size() < DEPTH);
    for (int i = 0; i < NUM_CDB; i++) begin
      t = int'(cdb_tag[i*TAG_W +: TAG_W]);
      if (cdb_valid[i] && m_valid[t]) begin
        m_ready[t] = 1; m_val[t] = cdb_val[i*DATA_W +: DATA_W]; m_exc[t] = cdb_exc[i];
      end
    end
    if (fire) begin void'(q.pop_front()); m_valid[h] = 0; end
    if (acc) begin
      m_valid[m_tail] = 1; m_ready[m_tail] = 0; m_exc[m_tail] = 0;
      m_areg[m_tail] = dest_arch_reg; m_store[m_tail] = is_store;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic cyc();
    #1;
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    flush = 0; allocate = 0; is_store = 0; commit_ack = 0; dest_arch_reg = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0; cdb_exc = '0; query_tag = '0;
  endtask

  task automatic cdb(input int port, input int tag, input logic [31:0] v, input bit e);
    cdb_valid[port] = 1'b1;
    cdb_tag[port*TAG_W +: TAG_W] = TAG_W'(tag);
    cdb_val[port*DATA_W +: DATA_W] = v;
    cdb_exc[port] = e;
  endtask

  // Asynchronous reset: outputs are checked mid-cycle, before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    m_clear();
    #2;
    check_outs();
    chk("rst_commit_valid", commit_valid, 1'b0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic alloc_n(input int n);
    for (int k = 0; k < n; k++) begin
      idle(); allocate = 1; dest_arch_reg = AREG_W'(k + 3); is_store = k[0];
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    m_clear();
    #2;
    check_outs();
    @(posedge clk); #1;
    reset = 0;

    // Fill to full, then a dropped ninth allocation
    alloc_n(8);
    #1;
    chk("full_after_8", rob_full, 1'b1);
    chk("count_after_8", count, 8);
    allocate = 1;
    cyc();
    idle(); #1;
    chk("tail_after_drop", alloc_tag, 0);
    chk("count_after_drop", count, 8);

    // Out-of-order completion, in-order commit
    do_reset();
    alloc_n(2);
    cdb(0, 1, 32'hAA, 0); cyc();
    idle(); #1;
    chk("no_commit_tag1_only", commit_valid, 1'b0);
    cdb(0, 0, 32'h55, 0); cyc();
    idle(); #1;
    chk("commit0_valid", commit_valid, 1'b1);
    chk("commit0_val", commit_val, 32'h55);
    commit_ack = 1; cyc();
    chk("commit1_tag", commit_tag, 1);
    chk("commit1_val", commit_val, 32'hAA);
    cyc();
    idle(); #1;
    chk("empty_after_commits", rob_empty, 1'b1);

    // Full ROB: commit and allocate together, allocation dropped
    do_reset();
    alloc_n(8);
    cdb(0, 0, 32'h77, 0); cyc();
    idle(); allocate = 1; commit_ack = 1; cyc();
    idle(); #1;
    chk("count_commit_vs_full", count, 7);
    chk("tail_commit_vs_full", alloc_tag, 0);

    // Both CDB ports to tag 3: port 1 wins, also on the query bypass
    cdb(0, 3, 32'h11, 0); cdb(1, 3, 32'h22, 0); query_tag = 3;
    #1;
    chk("bypass_ready", query_ready, 1'b1);
    chk("bypass_val", query_val, 32'h22);
    cyc();
    idle(); query_tag = 3; #1;
    chk("stored_val3", query_val, 32'h22);
    chk("stored_ready3", query_ready, 1'b1);

    // Wrap the pointers past 7 then flush with a competing allocate
    do_reset();
    alloc_n(6);
    for (int k = 0; k < 6; k += 2) begin
      idle(); cdb(0, k, 32'h100 + k, 0); cdb(1, k + 1, 32'h101 + k, 0); cyc();
    end
    idle(); commit_ack = 1;
    for (int k = 0; k < 6; k++) cyc();
    alloc_n(4);
    #1;
    chk("wrap_tail", alloc_tag, 2);
    chk("wrap_count", count, 4);
    flush = 1; allocate = 1; cyc();
    idle(); #1;
    chk("flush_count", count, 0);
    chk("flush_empty", rob_empty, 1'b1);
    chk("flush_tail", alloc_tag, 0);
    chk("flush_head", commit_tag, 0);
    cdb(0, 6, 32'hDEAD, 0); cyc();
    idle(); query_tag = 6; #1;
    chk("flush_no_valid", query_ready, 1'b0);

    // Exception reported at commit, then an asynchronous reset mid-sequence
    alloc_n(1);
    cdb(0, 0, 32'h99, 1); cyc();
    idle(); #1;
    chk("exc_commit_valid", commit_valid, 1'b1);
    chk("exc_commit_exc", commit_exc, 1'b1);
    alloc_n(3);
    do_reset();
    chk("post_rst_tag", alloc_tag, 0);
    chk("post_rst_full", rob_full, 1'b0);
    alloc_n(1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      allocate = ($urandom_range(0, 2) != 0);
      dest_arch_reg = AREG_W'($urandom);
      is_store = 1'($urandom);
      for (int p = 0; p < NUM_CDB; p++)
        if ($urandom_range(0, 1) == 1) cdb(p, $urandom_range(0, DEPTH - 1), $urandom, ($urandom_range(0, 7) == 0));
      commit_ack = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      query_tag = TAG_W'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_reorder_buffer.md
PARAM_REORDER_BUFFER -- requirements
Module: param_reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of 2, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have parameter AREG_W, default 5, architectural register index width.
REQ-004 SHALL have parameter NUM_CDB, default 2, number of CDB write ports.
REQ-005 SHALL derive TAG_W = clog2(DEPTH) and CNT_W = TAG_W+1 internally.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port flush, input, 1, discard all entries.
REQ-009 SHALL have ports allocate (in, 1), dest_arch_reg (in, AREG_W), is_store (in, 1): allocation request.
REQ-010 SHALL have ports alloc_tag (out, TAG_W) and rob_full (out, 1).
REQ-011 SHALL have ports cdb_valid (in, NUM_CDB), cdb_tag (in, NUM_CDB*TAG_W), cdb_val (in, NUM_CDB*DATA_W), cdb_exc (in, NUM_CDB); port i occupies slice i.
REQ-012 SHALL have ports query_tag (in, TAG_W), query_ready (out, 1), query_val (out, DATA_W): operand read port.
REQ-013 SHALL have ports commit_valid, commit_is_store, commit_exc (out, 1), commit_arch_reg (out, AREG_W), commit_val (out, DATA_W), commit_tag (out, TAG_W), commit_ack (in, 1).
REQ-014 SHALL have ports count (out, CNT_W) and rob_empty (out, 1).

Function
REQ-015 SHALL hold per entry: valid, ready, exc, arch_reg, value, is_store; head, tail (TAG_W, wrap modulo DEPTH) and count registers.
REQ-016 rob_full SHALL equal (count==DEPTH), rob_empty SHALL equal (count==0), both from registered count.
REQ-017 alloc_tag SHALL combinationally equal tail; allocation accepted iff allocate && !rob_full.
REQ-018 On accepted allocation, the edge SHALL set entry[tail] valid=1, ready=0, exc=0, store arch_reg/is_store, and advance tail by 1 with wrap.
REQ-019 Allocation while rob_full SHALL be dropped with no state change, even if a commit occurs in the same cycle.
REQ-020 For each i with cdb_valid[i] and entry[cdb_tag_i] valid, the edge SHALL set ready=1, value=cdb_val_i, exc=cdb_exc_i; writes to invalid entries are ignored.
REQ-021 Two CDB ports writing the same tag in one cycle: higher port index SHALL win.
REQ-022 commit_valid SHALL combinationally equal valid[head] && ready[head]; commit_* fields SHALL show entry[head] and commit_tag=head.
REQ-023 commit_valid && commit_ack SHALL clear valid[head] and advance head at the edge; commit_ack without commit_valid is ignored.
REQ-024 A CDB write to head SHALL make commit_valid rise the following cycle (registered ready, no same-cycle bypass).
REQ-025 count SHALL increment on accepted allocate only, decrement on commit only, unchanged when both occur.
REQ-026 query_ready/query_val SHALL be combinational: if any cdb_valid[i] hits query_tag that cycle, return 1 and that cdb_val (highest index wins); else ready[query_tag] and value[query_tag].
REQ-027 flush SHALL have priority over allocate, CDB and commit: edge clears all valid/ready/exc, head=tail=count=0.
REQ-028 Commit of an entry with exc=1 SHALL be reported via commit_exc only; flushing is the consumer's responsibility.
REQ-029 Entry arch_reg/value contents need not be reset; control state SHALL be.

Reset
REQ-030 While reset=1, asynchronously: head=tail=count=0, all valid/ready/exc=0; thus rob_empty=1, rob_full=0, commit_valid=0, alloc_tag=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries identically to REQ-030; first edge after deassertion behaves as from empty.

Verification (DEPTH=8, NUM_CDB=2)
REQ-032 Reset, allocate 8 back-to-back -> alloc_tag 0..7, rob_full=1, count=8; 9th allocate dropped, tail stays 0.
REQ-033 Alloc tags 0,1; CDB port0 writes tag1=0xAA, then tag0=0x55 -> commit_valid only after tag0 ready; commits tag0 (0x55) then tag1 (0xAA) in order.
REQ-034 Full ROB, head ready, allocate+commit_ack same cycle -> commit accepted, allocation dropped, count=7.
REQ-035 Both CDB ports write tag3 (0x11 port0, 0x22 port1) same cycle -> value[3]=0x22; query_tag=3 that cycle -> query_ready=1, query_val=0x22.
REQ-036 Head at 6, allocate through wrap to tag 1, flush with allocate asserted -> count=0, head=tail=0, rob_empty=1, no entry valid.
REQ-037 CDB to tag0 with cdb_exc=1 -> commit_exc=1 with commit_valid next cycle; reset pulse mid-sequence -> all outputs at REQ-030 values.
